// File: rtl/divider_share_arbiter_if.sv
// Request/response bundle between the requesting datapath blocks and the shared divider arbiter.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface divider_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_n;
  logic [8*NREQ-1:0]  req_d;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_q;
  logic [7:0]         rsp_r;
  logic               rsp_dz;
  logic               rsp_ovf;

  modport master (
    output req_valid, req_n, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf
  );

  modport slave (
    input  req_valid, req_n, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf
  );
endinterface

// File: rtl/divider_share_arbiter.sv
// Round-robin sequencer time-sharing one combinational 16/8 array divider among NREQ requesters.
// Define DIVARB_OPCNT_EN to add the 16-bit op_count output counting response handshakes.
module divider_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  divider_share_arbiter_if.slave bus,
  output logic [15:0]            div_n,
  output logic [7:0]             div_d,
  input  logic [7:0]             div_q,
  input  logic [7:0]             div_r,
  output logic                   busy
`ifdef DIVARB_OPCNT_EN
  ,
  output logic [15:0]            op_count
`endif
);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [15:0]      op_n_q, op_n_d;
  logic [7:0]       op_d_q, op_d_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  logic             op_ovf_q, op_ovf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_q_q, rsp_q_d;
  logic [7:0]       rsp_r_q, rsp_r_d;
  logic             rsp_dz_q, rsp_dz_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [15:0]      sel_n;
  logic [7:0]       sel_d;
  logic [NREQ-1:0]  ready_vec;
  logic             rsp_fire;

  // Search upward from the requester after the last grant, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && bus.req_valid[i] && (((int'(last_grant_q) + k) % NREQ) == i)) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_n     = '0;
    sel_d     = '0;
    ready_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_n        = bus.req_n[16*i +: 16];
        sel_d        = bus.req_d[8*i +: 8];
        ready_vec[i] = rst_n && (state_q == IDLE) && grant_found;
      end
    end
  end

  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_n_d       = op_n_q;
    op_d_d       = op_d_q;
    op_id_d      = op_id_q;
    op_ovf_d     = op_ovf_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_q_d      = rsp_q_q;
    rsp_r_d      = rsp_r_q;
    rsp_dz_d     = rsp_dz_q;
    rsp_ovf_d    = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          last_grant_d = grant_idx;
          op_n_d       = sel_n;
          op_d_d       = sel_d;
          op_id_d      = grant_idx;
          op_ovf_d     = (sel_d != 8'd0) && (sel_n[15:8] >= sel_d);
          // A zero divisor is answered immediately without waiting on the array.
          if (sel_d == 8'd0) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_q_d     = 8'hFF;
            rsp_r_d     = sel_n[7:0];
            rsp_dz_d    = 1'b1;
            rsp_ovf_d   = 1'b0;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = op_id_q;
          rsp_q_d     = div_q;
          rsp_r_d     = div_r;
          rsp_dz_d    = 1'b0;
          rsp_ovf_d   = op_ovf_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
      op_n_q       <= '0;
      op_d_q       <= '0;
      op_id_q      <= '0;
      op_ovf_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_q_q      <= '0;
      rsp_r_q      <= '0;
      rsp_dz_q     <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_n_q       <= op_n_d;
      op_d_q       <= op_d_d;
      op_id_q      <= op_id_d;
      op_ovf_q     <= op_ovf_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q_q      <= rsp_q_d;
      rsp_r_q      <= rsp_r_d;
      rsp_dz_q     <= rsp_dz_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

`ifdef DIVARB_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_fire) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_dz    = rsp_dz_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign div_n         = op_n_q;
  assign div_d         = op_d_q;
  assign busy          = (state_q != IDLE);
endmodule
